// File: rtl/connect4_pkg.sv
// connect4_pkg: shared token-drop state encoding and keyboard keycodes
package connect4_pkg;
  typedef enum logic [1:0] {HOVER, FALL, LAND} drop_state_t;
  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_DROP  = 8'h2C;
endpackage

// File: rtl/token_drop_ctrl_key_edge_detect.sv
// key_edge_detect: registers the previous keycode and emits one-frame press pulses
module key_edge_detect
  import connect4_pkg::*;
(
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  output logic       left_p,
  output logic       right_p,
  output logic       drop_p
);
  logic [7:0] prev_key;
  // prev_key tracks the keycode every frame, regardless of controller state
  always_ff @(posedge frame_clk or negedge Reset)
    if (!Reset) prev_key <= '0;
    else prev_key <= keycode;
  assign left_p  = keycode == KEY_LEFT  && prev_key != KEY_LEFT;
  assign right_p = keycode == KEY_RIGHT && prev_key != KEY_RIGHT;
  assign drop_p  = keycode == KEY_DROP  && prev_key != KEY_DROP;
endmodule

// File: rtl/token_drop_ctrl.sv
// token_drop_ctrl: token cursor, per-frame fall animation and drop handshake (CURSOR_WRAP_EN enables cursor wrap)
module token_drop_ctrl
  import connect4_pkg::*;
#(
  parameter int COLS      = 7,
  parameter int ROWS      = 6,
  parameter int CELL_W    = 64,
  parameter int CELL_H    = 64,
  parameter int X0        = 96,
  parameter int Y0        = 112,
  parameter int FALL_STEP = 8
) (
  input  logic                      frame_clk,
  input  logic                      Reset,
  input  logic [7:0]                keycode,
  input  logic [$clog2(ROWS)-1:0]   land_row,
  input  logic                      col_full,
  input  logic                      drop_ready,
  output logic [$clog2(COLS)-1:0]   cursor_col,
  output logic [9:0]                BallX,
  output logic [9:0]                BallY,
  output logic                      busy,
  output logic                      drop_valid,
  output logic [$clog2(COLS)-1:0]   drop_col,
  output logic [$clog2(ROWS)-1:0]   drop_row
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam logic [9:0] HOVER_Y = 10'(Y0 - CELL_H);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
  drop_state_t state;
  logic [RW-1:0] tgt_row;
  logic [9:0] tgt_y;
  logic [10:0] fall_sum;
  logic [CW-1:0] col_left, col_right;
  logic left_p, right_p, drop_p;
  key_edge_detect u_keys (
    .frame_clk(frame_clk),
    .Reset(Reset),
    .keycode(keycode),
    .left_p(left_p),
    .right_p(right_p),
    .drop_p(drop_p)
  );
  // neighbour columns: wrap around or saturate at the board edges
  always_comb begin
`ifdef CURSOR_WRAP_EN
    col_left  = cursor_col == '0 ? LAST_COL : cursor_col - 1'b1;
    col_right = cursor_col == LAST_COL ? '0 : cursor_col + 1'b1;
`else
    col_left  = cursor_col == '0 ? cursor_col : cursor_col - 1'b1;
    col_right = cursor_col == LAST_COL ? cursor_col : cursor_col + 1'b1;
`endif
    fall_sum  = {1'b0, BallY} + 11'(FALL_STEP);
  end
  assign BallX      = 10'(X0 + int'(cursor_col) * CELL_W);
  assign busy       = state != HOVER;
  assign drop_valid = state == LAND;
  // hover/fall/land sequencing with cursor and fall datapath
  always_ff @(posedge frame_clk or negedge Reset)
    if (!Reset) begin
      state      <= HOVER;
      cursor_col <= CW'(COLS / 2);
      BallY      <= HOVER_Y;
      tgt_row    <= '0;
      tgt_y      <= '0;
      drop_col   <= '0;
      drop_row   <= '0;
    end else
      case (state)
        HOVER:
          if (left_p) cursor_col <= col_left;
          else if (right_p) cursor_col <= col_right;
          else if (drop_p && !col_full) begin
            tgt_row <= land_row;
            tgt_y   <= 10'(Y0 + int'(land_row) * CELL_H);
            state   <= FALL;
          end
        FALL:
          if (fall_sum >= {1'b0, tgt_y}) begin
            BallY    <= tgt_y;
            drop_col <= cursor_col;
            drop_row <= tgt_row;
            state    <= LAND;
          end else BallY <= fall_sum[9:0];
        LAND:
          if (drop_ready) begin
            BallY <= HOVER_Y;
            state <= HOVER;
          end
        default: state <= HOVER;
      endcase
endmodule
